// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with load-use stall, write-through capture and MEM/WB operand forwarding
module ex_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [WIDTH-1:0]  id_rs1_data,
  input  logic [WIDTH-1:0]  id_rs2_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_alu_src_pc,
  input  logic              id_alu_src_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_result,
  output logic              id_stall,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_ctrl,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [REG_AW-1:0] ex_rd,
  output logic [WIDTH-1:0]  ex_pc,
  output logic [WIDTH-1:0]  ex_store_data
);
  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_ctrl;
    logic              src_pc;
    logic              src_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } ex_t;
  ex_t ex_q, ex_d, cap;
  logic lu;
  logic [WIDTH-1:0] fwd_rs1, fwd_rs2;
  function automatic logic [WIDTH-1:0] wt(input logic [REG_AW-1:0] rs, input logic [WIDTH-1:0] v);
    return (wb_reg_write && wb_rd != '0 && wb_rd == rs) ? wb_result : v;
  endfunction
  function automatic logic [WIDTH-1:0] fwd(input logic [REG_AW-1:0] rs, input logic [WIDTH-1:0] v);
    return rs == '0 ? '0
      : (mem_reg_write && mem_rd == rs) ? mem_result
      : (wb_reg_write && wb_rd == rs) ? wb_result : v;
  endfunction
  assign lu = ex_q.valid && ex_q.mem_read && ex_q.rd != '0 && id_valid &&
              ((id_uses_rs1 && id_rs1 == ex_q.rd) || (id_uses_rs2 && id_rs2 == ex_q.rd));
  assign id_stall = ex_stall || lu;
  always_comb begin
    cap           = '0;
    cap.valid     = id_valid;
    cap.pc        = id_pc;
    cap.imm       = id_imm;
    cap.rs1_data  = wt(id_rs1, id_rs1_data);
    cap.rs2_data  = wt(id_rs2, id_rs2_data);
    cap.rs1       = id_rs1;
    cap.rs2       = id_rs2;
    cap.rd        = id_rd;
    cap.alu_ctrl  = id_alu_ctrl;
    cap.src_pc    = id_alu_src_pc;
    cap.src_imm   = id_alu_src_imm;
    cap.reg_write = id_valid && id_reg_write;
    cap.mem_read  = id_valid && id_mem_read;
    cap.mem_write = id_valid && id_mem_write;
    cap.branch    = id_valid && id_branch;
    ex_d          = ex_stall ? ex_q : (flush || lu) ? '0 : cap;
  end
  always_ff @(posedge clk) ex_q <= rst_n ? ex_d : '0;
  assign fwd_rs1       = fwd(ex_q.rs1, ex_q.rs1_data);
  assign fwd_rs2       = fwd(ex_q.rs2, ex_q.rs2_data);
  assign alu_a         = ex_q.src_pc ? ex_q.pc : fwd_rs1;
  assign alu_b         = ex_q.src_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_rd         = ex_q.rd;
  assign ex_pc         = ex_q.pc;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed stimulus with a queue-based scoreboard checked by an independent monitor
module tb_ex_operand_stage;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_alu_src_pc, id_alu_src_imm;
  logic id_reg_write, id_mem_read, id_mem_write, id_branch, flush, ex_stall;
  logic mem_reg_write, wb_reg_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [3:0] id_alu_ctrl;
  logic id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0] alu_ctrl;
  logic [4:0] ex_rd;
  int total = 0, passed = 0;
  typedef struct {
    string       nm;
    int          f;
    logic [31:0] v;
  } exp_t;
  exp_t q[$];
  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src_pc(id_alu_src_pc), .id_alu_src_imm(id_alu_src_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .flush(flush), .ex_stall(ex_stall),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_store_data(ex_store_data)
  );
  always #5 clk = ~clk;
  localparam int STALL = 0, A = 1, B = 2, CTRL = 3, VALID = 4, SD = 5, PC = 6, CB = 7, RD = 8;
  function automatic logic [31:0] act(input int f);
    case (f)
      STALL:   return {31'd0, id_stall};
      A:       return alu_a;
      B:       return alu_b;
      CTRL:    return {28'd0, alu_ctrl};
      VALID:   return {31'd0, ex_valid};
      SD:      return ex_store_data;
      PC:      return ex_pc;
      CB:      return {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch};
      default: return {27'd0, ex_rd};
    endcase
  endfunction
  always begin
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (act(e.f) === e.v) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, act(e.f), e.v);
    end
  end
  initial begin
    repeat (500) @(posedge clk);
    $display("FAIL timeout: test did not finish in 500 cycles");
    $finish;
  end
  task automatic ex(input string nm, input int f, input logic [31:0] v);
    q.push_back('{nm, f, v});
  endtask
  task automatic clr();
    {id_valid, id_uses_rs1, id_uses_rs2, id_alu_src_pc, id_alu_src_imm} = '0;
    {id_reg_write, id_mem_read, id_mem_write, id_branch, flush, ex_stall} = '0;
    {mem_reg_write, wb_reg_write} = '0;
    {id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result} = '0;
    {id_rs1, id_rs2, id_rd, mem_rd, wb_rd} = '0;
    id_alu_ctrl = '0;
  endtask
  task automatic cyc();
    @(negedge clk);
    clr();
  endtask
  initial begin
    clr();
    rst_n = 0;
    @(negedge clk);
    cyc(); rst_n = 1;
    #0;
    total++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, id_stall} === 6'd0 &&
        alu_a === 32'd0 && alu_b === 32'd0 && alu_ctrl === 4'd0 && ex_rd === 5'd0 &&
        ex_pc === 32'd0 && ex_store_data === 32'd0) passed++;
    else $display("FAIL reset_state: outputs not all zero after reset");
    ex("rst_valid", VALID, 0); ex("rst_a", A, 0); ex("rst_b", B, 0);
    ex("rst_ctrl", CTRL, 0); ex("rst_pc", PC, 0); ex("rst_stall", STALL, 0); ex("rst_cb", CB, 0);
    cyc(); id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 5; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rs1_data = 3; id_rs2_data = 4; id_alu_ctrl = 4'h2; id_reg_write = 1;
    cyc(); id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_rd = 6; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rs1_data = 0; id_rs2_data = 3; id_alu_ctrl = 4'h2; id_reg_write = 1;
    ex("add1_a", A, 3); ex("add1_b", B, 4); ex("add1_ctrl", CTRL, 2);
    ex("add1_valid", VALID, 1); ex("add1_rd", RD, 5); ex("add1_stall", STALL, 0);
    cyc(); mem_reg_write = 1; mem_rd = 5; mem_result = 7;
    ex("add2_a_memfwd", A, 7); ex("add2_b", B, 3); ex("add2_rd", RD, 6);
    cyc(); id_valid = 1; id_rs1 = 7; id_uses_rs1 = 1; id_rs1_data = 1; id_rd = 10;
    id_alu_ctrl = 4'h2; id_reg_write = 1;
    ex("idle_valid", VALID, 0); ex("idle_cb", CB, 0);
    cyc(); wb_reg_write = 1; wb_rd = 7; wb_result = 10; mem_reg_write = 1; mem_rd = 7; mem_result = 20;
    id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1; id_rd = 10; id_alu_ctrl = 4'h2; id_reg_write = 1;
    ex("dbl_mem_wins", A, 20);
    cyc(); wb_reg_write = 1; wb_rd = 0; wb_result = 55; mem_reg_write = 1; mem_rd = 0; mem_result = 99;
    ex("x0_no_fwd", A, 0);
    cyc(); id_valid = 1; id_rs1 = 1; id_uses_rs1 = 1; id_rs1_data = 32'h100; id_imm = 4;
    id_alu_src_imm = 1; id_rd = 8; id_mem_read = 1; id_reg_write = 1; id_alu_ctrl = 4'h2;
    ex("pre_lw_stall", STALL, 0);
    cyc(); id_valid = 1; id_rs1 = 8; id_rs2 = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rs1_data = 0; id_rs2_data = 3; id_rd = 9; id_alu_ctrl = 4'h2; id_reg_write = 1;
    ex("lw_a", A, 32'h100); ex("lw_b", B, 4); ex("lw_cb", CB, 4'b1100); ex("lw_rd", RD, 8);
    ex("lu_stall", STALL, 1);
    cyc(); id_valid = 1; id_rs1 = 8; id_rs2 = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rs1_data = 0; id_rs2_data = 3; id_rd = 9; id_alu_ctrl = 4'h2; id_reg_write = 1;
    mem_reg_write = 1; mem_rd = 8; mem_result = 32'h104;
    ex("lu_bubble_valid", VALID, 0); ex("lu_bubble_ctrl", CTRL, 0); ex("lu_bubble_cb", CB, 0);
    ex("lu_one_cycle", STALL, 0);
    cyc(); wb_reg_write = 1; wb_rd = 8; wb_result = 32'h1234;
    ex("lu_wbfwd_a", A, 32'h1234); ex("lu_add_b", B, 3); ex("lu_add_valid", VALID, 1); ex("lu_add_rd", RD, 9);
    cyc(); id_valid = 1; id_pc = 32'h40; id_rs1 = 2; id_rs2 = 3; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rs1_data = 4; id_rs2_data = 5; id_rd = 11; id_alu_ctrl = 4'h5; id_mem_write = 1;
    id_alu_src_imm = 1; id_imm = 8;
    for (int i = 0; i < 3; i++) begin
      cyc(); ex_stall = 1; flush = 1; id_valid = 1; id_rs1 = 4; id_uses_rs1 = 1; id_rs1_data = 9;
      id_rd = 12; id_alu_ctrl = 4'h3; id_reg_write = 1; id_pc = 32'h44;
      ex("st_hold_a", A, 4); ex("st_hold_b", B, 8); ex("st_hold_sd", SD, 5); ex("st_hold_pc", PC, 32'h40);
      ex("st_hold_ctrl", CTRL, 5); ex("st_hold_cb", CB, 4'b0010); ex("st_hold_valid", VALID, 1);
      ex("st_hold_stall", STALL, 1);
    end
    cyc(); flush = 1; id_valid = 1; id_rs1 = 4; id_uses_rs1 = 1; id_rs1_data = 9; id_rd = 12;
    id_alu_ctrl = 4'h3; id_reg_write = 1; id_pc = 32'h44;
    ex("st_after_a", A, 4); ex("st_after_pc", PC, 32'h40); ex("st_after_stall", STALL, 0);
    cyc(); id_valid = 1; id_rs1 = 3; id_uses_rs1 = 1; id_rs1_data = 0; id_rd = 13;
    id_alu_ctrl = 4'h2; id_reg_write = 1; wb_reg_write = 1; wb_rd = 3; wb_result = 32'h55;
    ex("flush_valid", VALID, 0); ex("flush_ctrl", CTRL, 0); ex("flush_pc", PC, 0); ex("flush_a", A, 0);
    cyc(); id_valid = 1; id_pc = 32'h100; id_imm = 32'h2000; id_alu_src_pc = 1; id_alu_src_imm = 1;
    id_rs2 = 4; id_rs2_data = 32'h11; id_rd = 14; id_alu_ctrl = 4'h2; id_reg_write = 1;
    ex("wt_a", A, 32'h55); ex("wt_rd", RD, 13);
    cyc(); mem_reg_write = 1; mem_rd = 4; mem_result = 32'h77; ex_stall = 1; rst_n = 0;
    id_valid = 1; id_rs1 = 14; id_uses_rs1 = 1;
    ex("auipc_a", A, 32'h100); ex("auipc_b", B, 32'h2000); ex("auipc_sd", SD, 32'h77);
    ex("auipc_pc", PC, 32'h100); ex("auipc_stall", STALL, 1);
    cyc(); rst_n = 1;
    ex("rst2_valid", VALID, 0); ex("rst2_a", A, 0); ex("rst2_b", B, 0); ex("rst2_sd", SD, 0);
    ex("rst2_pc", PC, 0); ex("rst2_ctrl", CTRL, 0); ex("rst2_cb", CB, 0); ex("rst2_rd", RD, 0);
    ex("rst2_stall", STALL, 0);
    @(negedge clk);
    #3;
    if (passed != total || q.size() != 0) $display("FAIL summary: %0d/%0d passed, %0d pending", passed, total, q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
